// File: rtl/surf_dac_pkg.sv
// Shared constants, state encoding and frame packing for the DAC shadow loader.
// No timing of its own; used by dac_loader and dac_spi_shifter.
package surf_dac_pkg;

    localparam logic [3:0] CMD_WRUPD   = 4'b0011;
    localparam int         FRAME_W     = 24;
    localparam int         NUM_CH      = 32;
    localparam int         CH_PER_CHIP = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } dac_state_t;

    // Write-and-update command for one channel of an 8-channel DAC chip.
    function automatic logic [FRAME_W-1:0] dac_frame(input logic [2:0]  sub_ch,
                                                     input logic [15:0] dat);
        return {CMD_WRUPD, 1'b0, sub_ch, dat};
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Serialises one 24-bit frame MSB first: CLK_DIV cycles sclk low then CLK_DIV high per bit.
// Latency: 48*CLK_DIV cycles from start to done; no backpressure, start is only legal while idle.
module dac_spi_shifter
    import surf_dac_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               nrst_i,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] word_i,
    output logic               sclk_o,
    output logic               din_o,
    output logic               done_o
);

    localparam int             DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
    localparam int             BW        = $clog2(FRAME_W);
    localparam logic [BW-1:0]  BIT_FIRST = BW'(FRAME_W - 1);

    logic [FRAME_W-1:0] r_sr;
    logic [DW-1:0]      r_div;
    logic [BW-1:0]      r_bit;
    logic               r_active;
    logic               r_sclk;
    logic               w_half_end;

    assign w_half_end = r_active && (r_div == DIV_LAST);
    // Final cycle of bit 0's high phase: the owner leaves SHIFT on this edge.
    assign done_o     = w_half_end && r_sclk && (r_bit == '0);
    assign sclk_o     = r_sclk;
    assign din_o      = r_sr[FRAME_W-1];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_sr     <= '0;
            r_div    <= '0;
            r_bit    <= '0;
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
        end else if (start_i) begin
            r_sr     <= word_i;
            r_div    <= '0;
            r_bit    <= BIT_FIRST;
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
        end else if (r_active) begin
            if (w_half_end) begin
                r_div <= '0;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else begin
                    r_sclk <= 1'b0;
                    if (r_bit == '0) begin
                        r_active <= 1'b0;
                    end else begin
                        r_bit <= r_bit - 1'b1;
                        r_sr  <= {r_sr[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_loader.sv
// 32x16 DAC shadow RAM with a full-pass serial loader into four 8-channel DACs on an update strobe.
// Latency: read 1 cycle, pass 32*(1+48*CLK_DIV+GAP_CYC) cycles; updates while busy collapse into one extra pass.
module dac_loader
    import surf_dac_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        dac_wr_i,
    input  logic [4:0]  dac_waddr_i,
    input  logic [15:0] dac_dat_i,
    input  logic [4:0]  dac_raddr_i,
    output logic [15:0] dac_dat_o,
    input  logic        dac_update_i,
    output logic        dac_busy_o,
    output logic        dac_sclk_o,
    output logic        dac_din_o,
    output logic [3:0]  dac_ncs_o
);

    localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [4:0]    CH_LAST  = 5'(NUM_CH - 1);

    logic [15:0]        r_ram [NUM_CH];
    logic [15:0]        r_dat;
    dac_state_t         r_state;
    logic [4:0]         r_ch;
    logic               r_pending;
    logic               r_busy;
    logic [3:0]         r_ncs;
    logic [GW-1:0]      r_gap;

    logic               w_start;
    logic               w_done;
    logic [1:0]         w_chip;
    logic [2:0]         w_sub;
    logic [FRAME_W-1:0] w_word;

    assign w_start = (r_state == ST_LOAD);
    assign w_chip  = 2'(r_ch / CH_PER_CHIP);
    assign w_sub   = 3'(r_ch % CH_PER_CHIP);
    // RAM is sampled at the end of LOAD, so a write on any earlier edge is picked up.
    assign w_word  = dac_frame(w_sub, r_ram[r_ch]);

    // Shadow contents survive reset so the host does not have to reload them.
    always_ff @(posedge clk_i) begin
        if (dac_wr_i) begin
            r_ram[dac_waddr_i] <= dac_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_dat <= '0;
        end else begin
            r_dat <= r_ram[dac_raddr_i];
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_ncs     <= 4'hF;
            r_gap     <= '0;
        end else begin
            if (dac_update_i && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (dac_update_i) begin
                        r_state <= ST_LOAD;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_ncs   <= ~(4'b0001 << w_chip);
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_done) begin
                        r_ncs   <= 4'hF;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (r_ch != CH_LAST) begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= ST_LOAD;
                        end else if (r_pending || dac_update_i) begin
                            // A request arriving on the final edge is folded into the restart.
                            r_pending <= 1'b0;
                            r_ch      <= '0;
                            r_state   <= ST_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dac_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .start_i (w_start),
        .word_i  (w_word),
        .sclk_o  (dac_sclk_o),
        .din_o   (dac_din_o),
        .done_o  (w_done)
    );

    assign dac_dat_o  = r_dat;
    assign dac_busy_o = r_busy;
    assign dac_ncs_o  = r_ncs;

endmodule

// File: tb/tb_dac_loader.sv
// Directed/randomised bench for dac_loader: SPI bus decoder scoreboard against a shadow RAM model.
module tb_dac_loader;
    import surf_dac_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int GAP_CYC   = 4;
    localparam int FRAME_CYC = 1 + 2 * FRAME_W * CLK_DIV + GAP_CYC;
    localparam int PASS_CYC  = NUM_CH * FRAME_CYC;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic        dac_wr_i;
    logic [4:0]  dac_waddr_i;
    logic [15:0] dac_dat_i;
    logic [4:0]  dac_raddr_i;
    logic [15:0] dac_dat_o;
    logic        dac_update_i;
    logic        dac_busy_o;
    logic        dac_sclk_o;
    logic        dac_din_o;
    logic [3:0]  dac_ncs_o;

    dac_loader #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .dac_wr_i     (dac_wr_i),
        .dac_waddr_i  (dac_waddr_i),
        .dac_dat_i    (dac_dat_i),
        .dac_raddr_i  (dac_raddr_i),
        .dac_dat_o    (dac_dat_o),
        .dac_update_i (dac_update_i),
        .dac_busy_o   (dac_busy_o),
        .dac_sclk_o   (dac_sclk_o),
        .dac_din_o    (dac_din_o),
        .dac_ncs_o    (dac_ncs_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_ram [NUM_CH];

    int          frame_cnt;
    int          mon_ch;
    logic        in_frame;
    logic        p_sclk;
    logic [23:0] sh;
    logic [23:0] exp_w;
    logic [3:0]  exp_ncs;
    int          rises;
    int          low_len;
    int          hi_len;
    logic [23:0] obs_w   [8][NUM_CH];
    logic [3:0]  obs_ncs [8][NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        dac_wr_i    = 1'b1;
        dac_waddr_i = a;
        dac_dat_i   = d;
        @(posedge clk_i); #1;
        dac_wr_i    = 1'b0;
        m_ram[a]    = d;
    endtask

    // Bus decoder: rebuilds each frame from ncs/sclk/din and compares to the RAM model.
    always @(negedge clk_i) begin
        if (!nrst_i) begin
            in_frame  = 1'b0;
            frame_cnt = 0;
            hi_len    = 0;
            rises     = 0;
            low_len   = 0;
            p_sclk    = 1'b0;
        end else begin
            if (!in_frame && dac_ncs_o != 4'hF) begin
                mon_ch   = frame_cnt % NUM_CH;
                in_frame = 1'b1;
                rises    = 0;
                low_len  = 0;
                sh       = '0;
                exp_w    = {CMD_WRUPD, 1'b0, 3'(mon_ch % CH_PER_CHIP), m_ram[mon_ch]};
                exp_ncs  = ~(4'b0001 << (mon_ch / CH_PER_CHIP));
                chk("ncs_sel", 32'(dac_ncs_o), 32'(exp_ncs));
                if (mon_ch != 0) chk("gap_len", hi_len, GAP_CYC + 1);
                if (frame_cnt / NUM_CH < 8) obs_ncs[frame_cnt / NUM_CH][mon_ch] = dac_ncs_o;
            end else if (in_frame && dac_ncs_o == 4'hF) begin
                in_frame = 1'b0;
                hi_len   = 0;
                chk("frame_word", 32'(sh), 32'(exp_w));
                chk("sclk_rises", rises, FRAME_W);
                chk("frame_len", low_len, 2 * FRAME_W * CLK_DIV);
                chk("sclk_idle", 32'(dac_sclk_o), 32'h0);
                if (frame_cnt / NUM_CH < 8) obs_w[frame_cnt / NUM_CH][mon_ch] = sh;
                frame_cnt++;
            end
            if (in_frame) begin
                low_len++;
                if (dac_sclk_o && !p_sclk) begin
                    sh = {sh[22:0], dac_din_o};
                    rises++;
                end
            end else begin
                hi_len++;
            end
            p_sclk = dac_sclk_o;
        end
    end

    initial begin
        logic [15:0] v;
        logic [15:0] old5;
        int          n;
        int          a;
        logic        found;

        nrst_i       = 1'b0;
        dac_wr_i     = 1'b0;
        dac_waddr_i  = '0;
        dac_dat_i    = '0;
        dac_raddr_i  = '0;
        dac_update_i = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_ram[i] = 16'h0;

        // Reset state
        @(negedge clk_i);
        chk("rst_ncs", 32'(dac_ncs_o), 32'hF);
        chk("rst_busy", 32'(dac_busy_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        nrst_i      = 1'b1;
        dac_raddr_i = 5'd5;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_dat", 32'(dac_dat_o), 32'h0);
        chk("rst_sclk", 32'(dac_sclk_o), 32'h0);
        chk("rst_din", 32'(dac_din_o), 32'h0);
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        chk("idle_ncs", 32'(dac_ncs_o), 32'hF);
        chk("idle_sclk", 32'(dac_sclk_o), 32'h0);
        chk("idle_busy", 32'(dac_busy_o), 32'h0);

        // Fill shadow RAM, then read back
        @(posedge clk_i); #1;
        for (int i = 0; i < NUM_CH; i++)
            wr(5'(i), (i == 3) ? 16'hA5C3 : (i == 12) ? 16'h1234 : 16'($urandom));
        dac_raddr_i = 5'd3;
        @(negedge clk_i);
        chk("rd_lat_old", 32'(dac_dat_o), 32'(m_ram[5]));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rd_ch3", 32'(dac_dat_o), 32'hA5C3);
        dac_raddr_i = 5'd12;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rd_ch12", 32'(dac_dat_o), 32'h1234);
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(NUM_CH - 1));
            dac_raddr_i = 5'(a);
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("rd_rand", 32'(dac_dat_o), 32'(m_ram[a]));
        end

        // Single pass, with a ch0 write on the update cycle
        @(posedge clk_i); #1;
        v            = 16'($urandom);
        dac_wr_i     = 1'b1;
        dac_waddr_i  = 5'd0;
        dac_dat_i    = v;
        dac_update_i = 1'b1;
        @(negedge clk_i);
        chk("busy_before", 32'(dac_busy_o), 32'h0);
        @(posedge clk_i); #1;
        dac_wr_i     = 1'b0;
        dac_update_i = 1'b0;
        m_ram[0]     = v;
        @(negedge clk_i);
        chk("busy_rise", 32'(dac_busy_o), 32'h1);
        n = 1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk_i);
            if (!dac_busy_o) break;
            n++;
        end
        chk("pass_len", n, PASS_CYC);
        chk("p0_ch0_word", 32'(obs_w[0][0]), {8'h0, 8'h30, v});
        chk("p0_ch3_word", 32'(obs_w[0][3]), 32'h33A5C3);
        chk("p0_ch3_ncs", 32'(obs_ncs[0][3]), 32'hE);
        chk("p0_ch12_word", 32'(obs_w[0][12]), 32'h341234);
        chk("p0_ch12_ncs", 32'(obs_ncs[0][12]), 32'hD);

        // Two extra requests plus mid-pass writes
        @(posedge clk_i); #1;
        old5         = m_ram[5];
        dac_update_i = 1'b1;
        @(posedge clk_i); #1;
        dac_update_i = 1'b0;
        n = 0;
        for (int k = 0; k < 40000; k++) begin
            @(negedge clk_i);
            if (!dac_busy_o) break;
            n++;
            @(posedge clk_i); #1;
            if (n == 1001) m_ram[5]  = 16'hFFFF;
            if (n == 1002) m_ram[20] = 16'h0F0F;
            dac_update_i = (n == 2000) || (n == 3000);
            dac_wr_i     = (n == 1000) || (n == 1001);
            dac_waddr_i  = (n == 1000) ? 5'd5 : 5'd20;
            dac_dat_i    = (n == 1000) ? 16'hFFFF : 16'h0F0F;
        end
        dac_update_i = 1'b0;
        dac_wr_i     = 1'b0;
        chk("double_len", n, 2 * PASS_CYC);
        chk("p1_ch5_old", 32'(obs_w[1][5]), {8'h0, 8'h35, old5});
        chk("p1_ch20_new", 32'(obs_w[1][20]), 32'h340F0F);
        chk("p1_ch20_ncs", 32'(obs_ncs[1][20]), 32'hB);
        chk("p2_ch5_new", 32'(obs_w[2][5]), 32'h35FFFF);

        // Request on the very cycle the pass returns to idle
        @(posedge clk_i); #1;
        dac_update_i = 1'b1;
        @(posedge clk_i); #1;
        dac_update_i = 1'b0;
        n = 0;
        for (int k = 0; k < 40000; k++) begin
            @(negedge clk_i);
            if (!dac_busy_o) break;
            n++;
            @(posedge clk_i); #1;
            dac_update_i = (n == PASS_CYC - 1);
        end
        dac_update_i = 1'b0;
        chk("return_len", n, 2 * PASS_CYC);

        // Reset in the middle of ch9's frame
        @(posedge clk_i); #1;
        dac_update_i = 1'b1;
        @(posedge clk_i); #1;
        dac_update_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (in_frame && (frame_cnt % NUM_CH) == 9) begin
                found = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        chk("ch9_reached", 32'(found), 32'h1);
        repeat (50) @(posedge clk_i);
        #1;
        nrst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_ncs", 32'(dac_ncs_o), 32'hF);
        chk("abort_sclk", 32'(dac_sclk_o), 32'h0);
        chk("abort_busy", 32'(dac_busy_o), 32'h0);
        @(posedge clk_i); #1;
        nrst_i      = 1'b1;
        dac_raddr_i = 5'd3;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("ram_survives", 32'(dac_dat_o), 32'hA5C3);
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        chk("no_resume_busy", 32'(dac_busy_o), 32'h0);
        chk("no_resume_ncs", 32'(dac_ncs_o), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
